// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals shared by imem_loader and its environment.
// The stream source is the master; the loader (which also drives the imem write port) is the slave.
interface imem_loader_if #(
   parameter int ADDR_W = 10
);
   logic              s_valid;
   logic              s_ready;
   logic [7:0]        s_data;
   logic              s_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: zero-fills imem, then packs a little-endian byte stream into 32-bit words and releases the core.
// Optional running checksum of loaded words is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   imem_loader_if.slave    bus,
   output logic            cpu_rst,
   output logic            done,
   output logic            overflow,
   output logic [ADDR_W:0] word_count,
   output logic [31:0]     checksum
);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_LOAD,
      S_FINISH,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t            state_reg,    state_next;
   logic [ADDR_W:0]   clr_cnt_reg,  clr_cnt_next;
   logic [1:0]        lane_reg,     lane_next;
   logic [31:0]       buf_reg,      buf_next;
   logic              s_ready_reg,  s_ready_next;
   logic              we_reg,       we_next;
   logic [ADDR_W-1:0] addr_reg,     addr_next;
   logic [31:0]       wdata_reg,    wdata_next;
   logic              cpu_rst_reg,  cpu_rst_next;
   logic              done_reg,     done_next;
   logic              ovf_reg,      ovf_next;
   logic [ADDR_W:0]   wc_reg,       wc_next;

   logic        fire;
   logic        wc_full;
   logic        word_done;
   logic [31:0] word_asm;

   // s_ready_reg is only ever high in LOAD, so it doubles as the state qualifier.
   assign fire      = bus.s_valid && s_ready_reg;
   assign wc_full   = (wc_reg == DEPTH_C);
   assign word_done = fire && !wc_full && ((lane_reg == 2'd3) || bus.s_last);

   // Lanes above the current byte are still zero in buf_reg, which gives the s_last zero padding.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign word_asm[8*gi +: 8] = (lane_reg == 2'(gi)) ? bus.s_data : buf_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_CLEAR;
         clr_cnt_reg <= '0;
         lane_reg    <= '0;
         buf_reg     <= '0;
         s_ready_reg <= 1'b0;
         we_reg      <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         cpu_rst_reg <= 1'b1;
         done_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         wc_reg      <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
         lane_reg    <= lane_next;
         buf_reg     <= buf_next;
         s_ready_reg <= s_ready_next;
         we_reg      <= we_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         cpu_rst_reg <= cpu_rst_next;
         done_reg    <= done_next;
         ovf_reg     <= ovf_next;
         wc_reg      <= wc_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      lane_next    = lane_reg;
      buf_next     = buf_reg;
      s_ready_next = s_ready_reg;
      we_next      = 1'b0;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      cpu_rst_next = cpu_rst_reg;
      done_next    = done_reg;
      ovf_next     = ovf_reg;
      wc_next      = wc_reg;

      case (state_reg)
         S_CLEAR: begin
            s_ready_next = 1'b0;
            if (clr_cnt_reg == DEPTH_C) begin
               state_next   = S_LOAD;
               s_ready_next = 1'b1;
            end else begin
               we_next      = 1'b1;
               addr_next    = clr_cnt_reg[ADDR_W-1:0];
               wdata_next   = '0;
               clr_cnt_next = clr_cnt_reg + 1'b1;
            end
         end
         S_LOAD: begin
            if (fire && wc_full) begin
               ovf_next     = 1'b1;
               s_ready_next = 1'b0;
               state_next   = S_ERR;
            end else if (word_done) begin
               we_next    = 1'b1;
               addr_next  = wc_reg[ADDR_W-1:0];
               wdata_next = word_asm;
               wc_next    = wc_reg + 1'b1;
               buf_next   = '0;
               lane_next  = '0;
               if (bus.s_last) begin
                  state_next   = S_FINISH;
                  s_ready_next = 1'b0;
               end
            end else if (fire) begin
               buf_next  = word_asm;
               lane_next = lane_reg + 1'b1;
            end
         end
         S_FINISH: begin
            s_ready_next = 1'b0;
            cpu_rst_next = 1'b0;
            done_next    = 1'b1;
            state_next   = S_DONE;
         end
         S_DONE, S_ERR: begin
            s_ready_next = 1'b0;
         end
         default: begin
            state_next   = S_ERR;
            s_ready_next = 1'b0;
         end
      endcase
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] sum_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_reg <= '0;
      end else if (word_done) begin
         sum_reg <= sum_reg + word_asm;
      end
   end

   assign checksum = sum_reg;
`else
   assign checksum = '0;
`endif

   assign bus.s_ready    = s_ready_reg;
   assign bus.imem_we    = we_reg;
   assign bus.imem_addr  = addr_reg;
   assign bus.imem_wdata = wdata_reg;
   assign cpu_rst        = cpu_rst_reg;
   assign done           = done_reg;
   assign overflow       = ovf_reg;
   assign word_count     = wc_reg;

endmodule
